// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared types for the pipeline sequencer: FSM states and the
//                per-stage enable/flush bundle.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } pipe_state_t;

    typedef struct packed {
        logic if_en;
        logic id_en;
        logic ex_en;
        logic mem_en;
        logic flush_ifid;
        logic flush_idex;
        logic flush_exmem;
    } stage_ctrl_t;

    localparam stage_ctrl_t c_CTRL_HOLD   = 7'b0000_000;
    localparam stage_ctrl_t c_CTRL_RUN    = 7'b1111_000;
    localparam stage_ctrl_t c_CTRL_BRANCH = 7'b1111_111;
    localparam stage_ctrl_t c_CTRL_BUBBLE = 7'b0011_010;

    // A load in EX whose result is needed by the instruction in ID.
    function automatic logic load_use_hazard(
        input logic                  ex_is_load,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic [REG_ADDR_W-1:0] id_rs1,
        input logic [REG_ADDR_W-1:0] id_rs2,
        input logic                  id_use_rs1,
        input logic                  id_use_rs2
    );
        return ex_is_load && (ex_rd != '0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                (id_use_rs2 && (id_rs2 == ex_rd)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_if
//  Description : Hazard/handshake bundle between the core datapath (master)
//                and the pipeline sequencer (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    import pipe_pkg::*;

    logic                  PC_sel;
    logic                  mem_access;
    logic                  dmem_ready;
    logic                  ex_is_load;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;

    logic                  if_en;
    logic                  id_en;
    logic                  ex_en;
    logic                  memRegEn;
    logic                  flush_ifid;
    logic                  flush_idex;
    logic                  flush_exmem;
    logic                  dmem_req;
    logic                  mem_err;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output PC_sel, mem_access, dmem_ready, ex_is_load, ex_rd,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  if_en, id_en, ex_en, memRegEn, flush_ifid, flush_idex,
               flush_exmem, dmem_req, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  PC_sel, mem_access, dmem_ready, ex_is_load, ex_rd,
               id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output if_en, id_en, ex_en, memRegEn, flush_ifid, flush_idex,
               flush_exmem, dmem_req, mem_err, stall_cnt, flush_cnt
    );

endinterface
`default_nettype wire

// File: rtl/pipe_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Synchronous-reset event counter that sticks at all-ones.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             inc,
    output logic      [CNT_W-1:0] q
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign q = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : 5-stage pipeline sequencer: load-use bubbles, branch flushes,
//                dmem wait-state freeze with timeout halt, event counters.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int N       = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  wire logic   clk,
    input  wire logic   rst,
    pipe_ctrl_if.slave  bus
);

    localparam int              c_WAIT_W   = $clog2(TIMEOUT) + 1;
    localparam [c_WAIT_W-1:0]   c_WAIT_MAX = c_WAIT_W'(TIMEOUT - 1);
    localparam [c_WAIT_W-1:0]   c_WAIT_ONE = c_WAIT_W'(1);

    generate
        if ((N < 1) || (TIMEOUT < 2)) begin : g_param_check
            $error("pipe_ctrl: N must be >= 1 and TIMEOUT >= 2");
        end
    endgenerate

    pipe_state_t         r_state;
    pipe_state_t         w_state_next;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_next;
    stage_ctrl_t         w_ctrl;
    logic                w_dmem_req;
    logic                w_stall_inc;
    logic                w_flush_inc;
    logic                w_hazard;

    assign w_hazard = load_use_hazard(bus.ex_is_load, bus.ex_rd, bus.id_rs1,
                                      bus.id_rs2, bus.id_use_rs1, bus.id_use_rs2);

    always_comb begin
        w_ctrl       = c_CTRL_HOLD;
        w_dmem_req   = 1'b0;
        w_stall_inc  = 1'b0;
        w_flush_inc  = 1'b0;
        w_state_next = r_state;
        w_wait_next  = r_wait_cnt;

        case (r_state)
            RUN: begin
                w_dmem_req = bus.mem_access;
                if (bus.mem_access && !bus.dmem_ready) begin
                    w_state_next = MEM_WAIT;
                    w_wait_next  = c_WAIT_ONE;
                    w_stall_inc  = 1'b1;
                end else if (bus.PC_sel) begin
                    // Squashing EX also kills any load causing a hazard.
                    w_ctrl      = c_CTRL_BRANCH;
                    w_flush_inc = 1'b1;
                end else if (w_hazard) begin
                    w_ctrl      = c_CTRL_BUBBLE;
                    w_stall_inc = 1'b1;
                end else begin
                    w_ctrl = c_CTRL_RUN;
                end
            end

            MEM_WAIT: begin
                w_dmem_req = 1'b1;
                if (bus.dmem_ready) begin
                    w_ctrl       = c_CTRL_RUN;
                    w_state_next = RUN;
                    w_wait_next  = '0;
                end else begin
                    w_stall_inc = 1'b1;
                    if (r_wait_cnt == c_WAIT_MAX) begin
                        w_state_next = ERR;
                    end else begin
                        w_wait_next = r_wait_cnt + 1'b1;
                    end
                end
            end

            ERR: begin
                w_state_next = ERR;
            end

            default: begin
                w_state_next = RUN;
                w_wait_next  = '0;
            end
        endcase

        if (rst) begin
            w_ctrl     = c_CTRL_HOLD;
            w_dmem_req = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_stall_inc),
        .q   (bus.stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_flush_inc),
        .q   (bus.flush_cnt)
    );

    assign bus.if_en       = w_ctrl.if_en;
    assign bus.id_en       = w_ctrl.id_en;
    assign bus.ex_en       = w_ctrl.ex_en;
    assign bus.memRegEn    = w_ctrl.mem_en;
    assign bus.flush_ifid  = w_ctrl.flush_ifid;
    assign bus.flush_idex  = w_ctrl.flush_idex;
    assign bus.flush_exmem = w_ctrl.flush_exmem;
    assign bus.dmem_req    = w_dmem_req;
    assign bus.mem_err     = (r_state == ERR);

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_ctrl
//  Description : Directed scoreboard bench for pipe_ctrl (TIMEOUT=4, CNT_W=2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int c_CNT_W   = 2;
    localparam int c_TIMEOUT = 4;

    // Packed expectation: {if,id,ex,mem}{ifid,idex,exmem} req err stall flush
    typedef struct {
        string       nm;
        logic [12:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(c_CNT_W)) bus ();

    pipe_ctrl #(
        .N       (32),
        .TIMEOUT (c_TIMEOUT),
        .CNT_W   (c_CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [12:0] ex(input logic [3:0] en, input logic [2:0] fl,
                                       input logic req, input logic err,
                                       input logic [1:0] sc, input logic [1:0] fc);
        return {en, fl, req, err, sc, fc};
    endfunction

    task automatic step(input string nm, input logic r, input logic pc,
                        input logic ma, input logic rdy, input logic ld,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic [12:0] exp_v);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = r;
        bus.PC_sel     = pc;
        bus.mem_access = ma;
        bus.dmem_ready = rdy;
        bus.ex_is_load = ld;
        bus.ex_rd      = rd;
        bus.id_rs1     = rs1;
        bus.id_rs2     = rs2;
        bus.id_use_rs1 = u1;
        bus.id_use_rs2 = u2;
        e.nm = nm;
        e.v  = exp_v;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t        e;
            logic [12:0] act;
            e   = sb_q.pop_front();
            act = {bus.if_en, bus.id_en, bus.ex_en, bus.memRegEn,
                   bus.flush_ifid, bus.flush_idex, bus.flush_exmem,
                   bus.dmem_req, bus.mem_err, bus.stall_cnt, bus.flush_cnt};
            n_checks++;
            if (act !== e.v) begin
                n_errors++;
                $display("FAIL %s: got en=%b fl=%b req=%b err=%b sc=%0d fc=%0d, expected en=%b fl=%b req=%b err=%b sc=%0d fc=%0d",
                         e.nm, act[12:9], act[8:6], act[5], act[4], act[3:2], act[1:0],
                         e.v[12:9], e.v[8:6], e.v[5], e.v[4], e.v[3:2], e.v[1:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.PC_sel = 0; bus.mem_access = 0; bus.dmem_ready = 0; bus.ex_is_load = 0;
        bus.ex_rd = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;

        //   name              r pc ma rdy ld rd  rs1 rs2 u1 u2   en       fl      rq er sc fc
        step("reset",          1, 0, 0, 0, 0, 0,  0,  0,  0, 0, ex(4'b0000, 3'b000, 0, 0, 0, 0));
        step("idle",           0, 0, 0, 0, 0, 0,  0,  0,  0, 0, ex(4'b1111, 3'b000, 0, 0, 0, 0));
        step("lu_rs2",         0, 0, 0, 0, 1, 5,  0,  5,  0, 1, ex(4'b0011, 3'b010, 0, 0, 0, 0));
        step("after_lu",       0, 0, 0, 0, 0, 0,  0,  0,  0, 0, ex(4'b1111, 3'b000, 0, 0, 1, 0));
        step("lu_rd0",         0, 0, 0, 0, 1, 0,  0,  0,  1, 1, ex(4'b1111, 3'b000, 0, 0, 1, 0));
        step("lu_unused_src",  0, 0, 0, 0, 1, 7,  7,  2,  0, 1, ex(4'b1111, 3'b000, 0, 0, 1, 0));
        step("branch",         0, 1, 0, 0, 0, 0,  0,  0,  0, 0, ex(4'b1111, 3'b111, 0, 0, 1, 0));
        step("branch_and_lu",  0, 1, 0, 0, 1, 3,  3,  0,  1, 0, ex(4'b1111, 3'b111, 0, 0, 1, 1));
        step("lu_rs1",         0, 0, 0, 0, 1, 3,  3,  0,  1, 0, ex(4'b0011, 3'b010, 0, 0, 1, 2));
        step("rst_counters",   1, 0, 0, 0, 0, 0,  0,  0,  0, 0, ex(4'b0000, 3'b000, 0, 0, 2, 2));
        step("idle2",          0, 0, 0, 0, 0, 0,  0,  0,  0, 0, ex(4'b1111, 3'b000, 0, 0, 0, 0));
        // Memory stall beats a simultaneous branch; wait state ignores hazards.
        step("mem_stall_pc",   0, 1, 1, 0, 0, 0,  0,  0,  0, 0, ex(4'b0000, 3'b000, 1, 0, 0, 0));
        step("wait1",          0, 1, 0, 0, 1, 4,  4,  0,  1, 0, ex(4'b0000, 3'b000, 1, 0, 1, 0));
        step("wait2",          0, 0, 1, 0, 0, 0,  0,  0,  0, 0, ex(4'b0000, 3'b000, 1, 0, 2, 0));
        step("wait_ready",     0, 1, 1, 1, 0, 0,  0,  0,  0, 0, ex(4'b1111, 3'b000, 1, 0, 3, 0));
        step("run_again",      0, 0, 0, 0, 0, 0,  0,  0,  0, 0, ex(4'b1111, 3'b000, 0, 0, 3, 0));
        step("mem_hit",        0, 0, 1, 1, 0, 0,  0,  0,  0, 0, ex(4'b1111, 3'b000, 1, 0, 3, 0));
        step("rst3",           1, 0, 0, 0, 0, 0,  0,  0,  0, 0, ex(4'b0000, 3'b000, 0, 0, 3, 0));
        // Timeout: four wait cycles then ERR.
        step("to_stall",       0, 0, 1, 0, 0, 0,  0,  0,  0, 0, ex(4'b0000, 3'b000, 1, 0, 0, 0));
        step("to_w1",          0, 0, 1, 0, 0, 0,  0,  0,  0, 0, ex(4'b0000, 3'b000, 1, 0, 1, 0));
        step("to_w2",          0, 0, 1, 0, 0, 0,  0,  0,  0, 0, ex(4'b0000, 3'b000, 1, 0, 2, 0));
        step("to_w3",          0, 0, 1, 0, 0, 0,  0,  0,  0, 0, ex(4'b0000, 3'b000, 1, 0, 3, 0));
        step("err_hold",       0, 1, 1, 1, 1, 6,  6,  0,  1, 0, ex(4'b0000, 3'b000, 0, 1, 3, 0));
        step("err_hold2",      0, 0, 0, 0, 0, 0,  0,  0,  0, 0, ex(4'b0000, 3'b000, 0, 1, 3, 0));
        step("err_rst",        1, 0, 0, 0, 0, 0,  0,  0,  0, 0, ex(4'b0000, 3'b000, 0, 1, 3, 0));
        step("post_err",       0, 0, 0, 0, 0, 0,  0,  0,  0, 0, ex(4'b1111, 3'b000, 0, 0, 0, 0));
        // Reset during the second wait cycle.
        step("rw_stall",       0, 0, 1, 0, 0, 0,  0,  0,  0, 0, ex(4'b0000, 3'b000, 1, 0, 0, 0));
        step("rw_w1",          0, 0, 1, 0, 0, 0,  0,  0,  0, 0, ex(4'b0000, 3'b000, 1, 0, 1, 0));
        step("rw_rst",         1, 0, 1, 0, 0, 0,  0,  0,  0, 0, ex(4'b0000, 3'b000, 0, 0, 2, 0));
        step("rw_after",       0, 0, 0, 0, 0, 0,  0,  0,  0, 0, ex(4'b1111, 3'b000, 0, 0, 0, 0));
        // Saturation of the 2-bit stall counter.
        step("sat_lu1",        0, 0, 0, 0, 1, 9,  9,  0,  1, 0, ex(4'b0011, 3'b010, 0, 0, 0, 0));
        step("sat_lu2",        0, 0, 0, 0, 1, 9,  9,  0,  1, 0, ex(4'b0011, 3'b010, 0, 0, 1, 0));
        step("sat_lu3",        0, 0, 0, 0, 1, 9,  9,  0,  1, 0, ex(4'b0011, 3'b010, 0, 0, 2, 0));
        step("sat_lu4",        0, 0, 0, 0, 1, 9,  9,  0,  1, 0, ex(4'b0011, 3'b010, 0, 0, 3, 0));
        step("sat_lu5",        0, 0, 0, 0, 1, 9,  0,  9,  0, 1, ex(4'b0011, 3'b010, 0, 0, 3, 0));
        step("sat_idle",       0, 0, 0, 0, 0, 0,  0,  0,  0, 0, ex(4'b1111, 3'b000, 0, 0, 3, 0));

        @(posedge clk);
        @(posedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
